// File: rtl/hdmi_timing_gen_if.sv
// hdmi_timing_gen_if
//   Bundles every signal of the HDMI timing generator apart from clock and reset.
//   master : the timing generator. It takes the run enable, the timing and format
//            settings, and the FIFO word/empty flag. It drives the pixel data,
//            the syncs, the markers and the FIFO pop strobe.
//   slave  : the surrounding system, which sees every signal in the opposite direction.
//   FIFO handshake: the FIFO is first-word-fall-through. color is valid whenever
//   fifo_empty is low. read_fifo is a pop strobe: in any cycle where it is high,
//   the current color word is consumed at the next rising edge. The generator never
//   waits on fifo_empty. Popping an empty FIFO only raises underflow.
interface hdmi_timing_gen_if #(
    parameter int CNT_W = 12
);
    logic             start;
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_sync;
    logic [CNT_W-1:0] h_bp_end;
    logic [CNT_W-1:0] h_act_end;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_sync;
    logic [CNT_W-1:0] v_bp_end;
    logic [CNT_W-1:0] v_act_end;
    logic             polarity;
    logic             cfg_update;
    logic [1:0]       pix_fmt;
    logic [31:0]      color;
    logic             fifo_empty;
    logic [7:0]       red;
    logic [7:0]       green;
    logic [7:0]       blue;
    logic             hsync;
    logic             vsync;
    logic             ve;
    logic             read_fifo;
    logic             frame_start;
    logic             line_start;
    logic             underflow;

    modport master (
        input  start, h_total, h_sync, h_bp_end, h_act_end,
               v_total, v_sync, v_bp_end, v_act_end,
               polarity, cfg_update, pix_fmt, color, fifo_empty,
        output red, green, blue, hsync, vsync, ve, read_fifo,
               frame_start, line_start, underflow
    );

    modport slave (
        output start, h_total, h_sync, h_bp_end, h_act_end,
               v_total, v_sync, v_bp_end, v_act_end,
               polarity, cfg_update, pix_fmt, color, fifo_empty,
        input  red, green, blue, hsync, vsync, ve, read_fifo,
               frame_start, line_start, underflow
    );
endinterface

// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen
//   Generates a video raster and its pixel data.
//   - Counters hcnt and vcnt run from shadowed timing values.
//   - hsync, vsync and ve are delayed by SYNC_DLY cycles.
//   - Words are popped from a FWFT FIFO and unpacked into RGB888, RGB565 or GRAY8 pixels.
//   Ports:
//     clock : rising-edge clock.
//     reset : synchronous, active-high reset.
//     bus   : hdmi_timing_gen_if.master, which carries the settings, the FIFO
//             side and the video outputs.
//   Parameters:
//     CNT_W    : counter and timing width.
//     SYNC_DLY : output pipeline depth. Legal values are 2..4.
module hdmi_timing_gen #(
    parameter int CNT_W    = 12,
    parameter int SYNC_DLY = 2
) (
    input  logic              clock,
    input  logic              reset,
    hdmi_timing_gen_if.master bus
);
    localparam logic [1:0]       FMT_565  = 2'b00;
    localparam logic [1:0]       FMT_GRAY = 2'b10;
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    // hold covers both reset and a stopped block. The behaviour is identical in either case.
    logic hold;
    assign hold = reset || !bus.start;

    // Timing shadow registers. Only these values feed the counters and the comparators.
    logic [CNT_W-1:0] sh_h_total, sh_h_sync, sh_h_bp_end, sh_h_act_end;
    logic [CNT_W-1:0] sh_v_total, sh_v_sync, sh_v_bp_end, sh_v_act_end;
    logic             sh_pol;
    logic [1:0]       sh_fmt;
    logic             pending;

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             h_last, v_last, frame_wrap, load_cfg;

    assign h_last     = (hcnt == sh_h_total - ONE);
    assign v_last     = (vcnt == sh_v_total - ONE);
    assign frame_wrap = h_last && v_last;
    // A request in the wrap cycle itself is honoured at that same wrap.
    assign load_cfg   = hold || (frame_wrap && (pending || bus.cfg_update));

    always_ff @(posedge clock) begin
        if (load_cfg) begin
            sh_h_total   <= bus.h_total;
            sh_h_sync    <= bus.h_sync;
            sh_h_bp_end  <= bus.h_bp_end;
            sh_h_act_end <= bus.h_act_end;
            sh_v_total   <= bus.v_total;
            sh_v_sync    <= bus.v_sync;
            sh_v_bp_end  <= bus.v_bp_end;
            sh_v_act_end <= bus.v_act_end;
            sh_pol       <= bus.polarity;
            sh_fmt       <= bus.pix_fmt;
        end
        if (load_cfg)            pending <= 1'b0;
        else if (bus.cfg_update) pending <= 1'b1;
    end

    always_ff @(posedge clock) begin
        if (hold) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + ONE;
        end else begin
            hcnt <= hcnt + ONE;
        end
    end

    // Stage 0: decode the counters.
    logic       hs0, vs0, act0, first0;
    logic [1:0] pix0;
    assign hs0    = (hcnt < sh_h_sync) ? sh_pol : ~sh_pol;
    assign vs0    = (vcnt < sh_v_sync) ? sh_pol : ~sh_pol;
    assign act0   = (hcnt >= sh_h_bp_end) && (hcnt < sh_h_act_end) &&
                    (vcnt >= sh_v_bp_end) && (vcnt < sh_v_act_end);
    // Only the pixel index mod 4 is ever needed, so the low two bits suffice.
    assign pix0   = hcnt[1:0] - sh_h_bp_end[1:0];
    assign first0 = (hcnt == '0) && (vcnt == '0);

    // Sync pipelines. Bit k holds the stage-0 value from k cycles ago.
    // act_q carries one extra stage so that the rising edge of ve can be seen.
    logic [SYNC_DLY:1]   hs_q, vs_q, fs_q;
    logic [SYNC_DLY+1:1] act_q;
    logic [1:0]          pix1, fmt1;

    always_ff @(posedge clock) begin
        if (hold) begin
            hs_q  <= '0;
            vs_q  <= '0;
            fs_q  <= '0;
            act_q <= '0;
            pix1  <= '0;
            fmt1  <= '0;
        end else begin
            hs_q  <= {hs_q[SYNC_DLY-1:1], hs0};
            vs_q  <= {vs_q[SYNC_DLY-1:1], vs0};
            fs_q  <= {fs_q[SYNC_DLY-1:1], first0};
            act_q <= {act_q[SYNC_DLY:1], act0};
            pix1  <= pix0;
            fmt1  <= sh_fmt;
        end
    end

    // Stage 1: the lane within the current word. A new word is popped on lane 0.
    logic [1:0] lane1;
    logic       rd;
    always_comb begin
        lane1 = 2'd0;
        case (fmt1)
            FMT_565:  lane1 = {1'b0, pix1[0]};
            FMT_GRAY: lane1 = pix1;
            default:  lane1 = 2'd0;
        endcase
    end
    // Gating with hold stops the pop in the very cycle that reset or stop arrives.
    assign rd = act_q[1] && (lane1 == 2'd0) && !hold;

    // Stages 2..SYNC_DLY: word, lane and format travel with the pixel.
    // Stage 2 holds its word across the lanes that follow each pop.
    logic [31:0] word_q [2:SYNC_DLY];
    logic [1:0]  lane_q [2:SYNC_DLY];
    logic [1:0]  fmt_q  [2:SYNC_DLY];
    logic        und_q;

    always_ff @(posedge clock) begin
        if (hold) begin
            for (int k = 2; k <= SYNC_DLY; k++) begin
                word_q[k] <= '0;
                lane_q[k] <= '0;
                fmt_q[k]  <= '0;
            end
            und_q <= 1'b0;
        end else begin
            if (rd) word_q[2] <= bus.color;
            lane_q[2] <= lane1;
            fmt_q[2]  <= fmt1;
            for (int k = 3; k <= SYNC_DLY; k++) begin
                word_q[k] <= word_q[k-1];
                lane_q[k] <= lane_q[k-1];
                fmt_q[k]  <= fmt_q[k-1];
            end
            if (rd && bus.fifo_empty) und_q <= 1'b1;
        end
    end

    // Output stage: unpack the pixel and blank it outside active video.
    logic [31:0] o_word;
    logic [1:0]  o_lane, o_fmt;
    logic        o_ve;
    logic [15:0] half;
    logic [7:0]  gray, r_px, g_px, b_px;

    assign o_word = word_q[SYNC_DLY];
    assign o_lane = lane_q[SYNC_DLY];
    assign o_fmt  = fmt_q[SYNC_DLY];
    assign o_ve   = act_q[SYNC_DLY];

    always_comb begin
        half = o_lane[0] ? o_word[31:16] : o_word[15:0];
        gray = o_word[7:0];
        r_px = 8'd0;
        g_px = 8'd0;
        b_px = 8'd0;
        case (o_lane)
            2'd0:    gray = o_word[7:0];
            2'd1:    gray = o_word[15:8];
            2'd2:    gray = o_word[23:16];
            default: gray = o_word[31:24];
        endcase
        if (o_ve) begin
            case (o_fmt)
                FMT_565: begin
                    r_px = {half[15:11], 3'b000};
                    g_px = {half[10:5], 2'b00};
                    b_px = {half[4:0], 3'b000};
                end
                FMT_GRAY: begin
                    r_px = gray;
                    g_px = gray;
                    b_px = gray;
                end
                default: begin
                    r_px = o_word[31:24];
                    g_px = o_word[23:16];
                    b_px = o_word[15:8];
                end
            endcase
        end
    end

    assign bus.red         = r_px;
    assign bus.green       = g_px;
    assign bus.blue        = b_px;
    assign bus.hsync       = hs_q[SYNC_DLY];
    assign bus.vsync       = vs_q[SYNC_DLY];
    assign bus.ve          = o_ve;
    assign bus.read_fifo   = rd;
    assign bus.frame_start = fs_q[SYNC_DLY];
    assign bus.line_start  = act_q[SYNC_DLY] && !act_q[SYNC_DLY+1];
    assign bus.underflow   = und_q;
endmodule

// File: doc/hdmi_timing_gen.md
HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

Interface
REQ-001 Parameter CNT_W, 12, width of the h/v counters and timing inputs (supports totals up to 2^CNT_W).
REQ-002 Parameter SYNC_DLY, 2, pipeline depth from the counters to the hsync, vsync and ve outputs (legal values 2..4).
REQ-003 clock  in  1  sole clock; all logic is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  run enable; low holds the block in the reset state (REQ-021).
REQ-006 h_total, h_sync, h_bp_end, h_act_end  in  CNT_W each  horizontal line length, sync end, back-porch end, active end.
REQ-007 v_total, v_sync, v_bp_end, v_act_end  in  CNT_W each  vertical equivalents, in lines.
REQ-008 polarity  in  1  sync active level.
REQ-009 cfg_update  in  1  single-cycle request to adopt the timing inputs.
REQ-010 pix_fmt  in  2  pixel format: 00 RGB565, 01 RGB888, 10 GRAY8, 11 reserved (treat as RGB888).
REQ-011 color  in  32  FIFO word; first-word-fall-through, so it is valid during read_fifo.
REQ-012 fifo_empty  in  1  FIFO empty flag.
REQ-013 red, green, blue  out  8 each  pixel data.
REQ-014 hsync, vsync, ve  out  1 each  syncs and video enable.
REQ-015 read_fifo  out  1  FIFO pop strobe.
REQ-016 frame_start, line_start  out  1 each  single-cycle markers.
REQ-017 underflow  out  1  sticky FIFO-underflow flag.

Function
REQ-018 Timing shadow registers SHALL hold all timing values and polarity; the counters and comparators SHALL use only the shadow registers.
REQ-019 A cfg_update pulse SHALL set a pending flag; the shadow registers SHALL load at the frame wrap, defined as hcnt=h_total-1 and vcnt=v_total-1; loading SHALL clear the pending flag.
REQ-020 cfg_update arriving in the same cycle as the frame wrap SHALL load at that wrap.
REQ-021 While reset or !start: shadow registers SHALL load every cycle, the pending flag and counters SHALL clear, and all pipeline registers and outputs SHALL be 0.
REQ-022 hcnt SHALL count 0..h_total-1 and then wrap to 0. vcnt SHALL increment on each hcnt wrap, counting 0..v_total-1 and then wrapping to 0.
REQ-023 Stage-0 signals:
- hs0 = polarity when hcnt<h_sync, else ~polarity; vs0 is the same using vcnt<v_sync.
- act0 = (h_bp_end<=hcnt<h_act_end) and (v_bp_end<=vcnt<v_act_end).
- pix0 = hcnt-h_bp_end, truncated to CNT_W.
REQ-024 hsync, vsync and ve SHALL equal hs0, vs0 and act0 delayed by exactly SYNC_DLY cycles.
REQ-025 Words-per-pixel divisor N SHALL be 1 for RGB888, 2 for RGB565 and 4 for GRAY8.
REQ-026 read_fifo SHALL be asserted in the cycle where act0 (delayed 1) is high and pix0 (delayed 1) mod N is 0.
REQ-027 The word on color SHALL be captured when read_fifo is high; lane = pix0 (delayed 1) mod N; lane and word SHALL be aligned to output stage SYNC_DLY.
REQ-028 Pixel mapping:
- RGB888: r=[31:24], g=[23:16], b=[15:8].
- RGB565 lane k (16-bit half h=[16k+15:16k]): r={h[15:11],000}, g={h[10:5],00}, b={h[4:0],000}.
- GRAY8 lane k: r=g=b=[8k+7:8k].
REQ-029 red, green and blue SHALL be 0 whenever ve is 0.
REQ-030 frame_start SHALL pulse for one cycle, aligned with the output stage of hcnt=0, vcnt=0.
REQ-031 line_start SHALL pulse on each rising edge of ve.
REQ-032 underflow SHALL set when read_fifo and fifo_empty are both high, SHALL hold until reset or !start, and SHALL NOT otherwise affect timing.
REQ-033 A pix_fmt change SHALL be sampled only at the frame wrap, together with the shadow load.
REQ-034 Timing inputs SHALL be required to satisfy h_sync<=h_bp_end<h_act_end<=h_total (vertical likewise); for inputs that violate this, counter wrap SHALL still follow REQ-022.

Reset
REQ-035 reset is synchronous, active-high and dominant over start and cfg_update.
REQ-036 After reset:
- all outputs SHALL be 0, including hsync and vsync (regardless of polarity).
- counters SHALL be 0 and the first counted cycle after deassertion SHALL be hcnt=0.
REQ-037 Reset asserted mid-frame SHALL abort the frame immediately, with no further read_fifo.

Verification
REQ-038 800x600 timing (1056/128/216/1016, 628/4/27/627), RGB888, polarity 0 -> per line ve high 800 cycles, read_fifo 800 cycles (leading ve by 1 cycle), hsync low 128 cycles; frame = 663168 cycles.
REQ-039 RGB565, color=0xF800_07E0 on every word -> read_fifo on alternate active cycles; output pixels alternate (0,252,0) then (248,0,0).
REQ-040 GRAY8, color=0x40302010 -> 4 pixels gray 0x10, 0x20, 0x30, 0x40 per word; read_fifo every 4th active cycle.
REQ-041 cfg_update issued mid-frame with 640x480 values -> current frame keeps old timing; next frame_start uses the new totals (800 cycles/line).
REQ-042 fifo_empty=1 during active video -> underflow=1 on the first read_fifo and stays set; deasserting start clears it.
REQ-043 reset asserted at hcnt=500 of an active line -> next cycle all outputs 0; after release, frame_start occurs SYNC_DLY cycles after the first counted cycle.
